// File: rtl/c2h_seg_framer_pkg.sv
// Shared types and width helpers for the C2H segmenter.
// Optional statistics ports are enabled by defining C2H_SEG_FRAMER_STATS_EN.
package c2h_seg_framer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } c2h_state_e;

  // Fixed-width view of a FIFO entry at the default 64-bit datapath.
  localparam int unsigned C2H_DEF_DATA_W = 64;

  typedef struct packed {
    logic [C2H_DEF_DATA_W-1:0]   tdata;
    logic [C2H_DEF_DATA_W/8-1:0] tkeep;
    logic                        tlast;
  } c2h_entry_t;

  function automatic int unsigned c2h_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned c2h_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/c2h_seg_fifo.sv
// First-word-fall-through FIFO with synchronous flush.
// The head entry is visible on o_data whenever o_empty is low.
module c2h_seg_fifo
  import c2h_seg_framer_pkg::*;
#(
  parameter int unsigned W     = 73,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic                          i_push,
  input  logic [W-1:0]                  i_data,
  input  logic                          i_pop,
  input  logic                          i_flush,
  output logic [W-1:0]                  o_data,
  output logic [c2h_cnt_w(DEPTH)-1:0]   o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int unsigned PW = c2h_ptr_w(DEPTH);
  localparam int unsigned CW = c2h_cnt_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/c2h_seg_framer.sv
// C2H segmenter: buffers source beats and re-frames them into segments of at most
// MAX_BEATS beats; flushes on PCIe link loss. Stats ports under C2H_SEG_FRAMER_STATS_EN.
module c2h_seg_framer
  import c2h_seg_framer_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BEATS  = 32
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                user_lnk_up,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                busy
`ifdef C2H_SEG_FRAMER_STATS_EN
  ,
  output logic [31:0]         stat_pkt_cnt,
  output logic [31:0]         stat_seg_cnt,
  output logic [31:0]         stat_drop_cnt
`endif
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned CNT_W  = c2h_cnt_w(FIFO_DEPTH);
  localparam int unsigned BC_W   = c2h_cnt_w(MAX_BEATS);
  localparam int unsigned ENT_W  = DATA_W + KEEP_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } entry_t;

  c2h_state_e       r_state;
  c2h_state_e       w_state_nxt;
  logic             r_out_en;
  logic [BC_W-1:0]  r_beat_cnt;
  entry_t           w_push_entry;
  entry_t           w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_seg_last;
  logic             w_pass_to_drop;

  assign w_push_entry = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};

  c2h_seg_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .i_push    (w_push),
    .i_data    (w_push_entry),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .o_data    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // r_out_en keeps s_axis_tready low while reset is held, including the idle state.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_out_en <= 1'b0;
    else            r_out_en <= 1'b1;
  end

  assign w_flush       = !user_lnk_up;
  assign s_axis_tready = r_out_en && ((r_state == DROP) || (user_lnk_up && !w_full));
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_push        = w_accept && (r_state != DROP);
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid = !w_empty;
  assign w_seg_last    = w_head.tlast || (r_beat_cnt == BC_W'(MAX_BEATS - 1));
  assign m_axis_tlast  = m_axis_tvalid && w_seg_last;
  assign m_axis_tdata  = m_axis_tvalid ? w_head.tdata : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? w_head.tkeep : '0;
  assign busy          = (w_count != '0) || (r_state != IDLE);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pass_to_drop = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && !s_axis_tlast) w_state_nxt = PASS;
      end
      PASS: begin
        if (!user_lnk_up) begin
          w_state_nxt    = DROP;
          w_pass_to_drop = 1'b1;
        end else if (w_accept && s_axis_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (w_accept && s_axis_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_flush) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= m_axis_tlast ? '0 : r_beat_cnt + 1'b1;
    end
  end

`ifdef C2H_SEG_FRAMER_STATS_EN
  logic [31:0]      r_pkt_cnt;
  logic [31:0]      r_seg_cnt;
  logic [31:0]      r_drop_cnt;
  logic [CNT_W-1:0] w_flushed;

  // A pop in the link-loss cycle still completes, so it is not counted as flushed.
  assign w_flushed = w_flush ? (w_count - CNT_W'(w_pop)) : '0;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pkt_cnt  <= '0;
      r_seg_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop && w_head.tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_pop && m_axis_tlast) r_seg_cnt <= r_seg_cnt + 32'd1;
      r_drop_cnt <= r_drop_cnt + 32'(w_pass_to_drop) + 32'(w_flushed);
    end
  end

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_seg_cnt  = r_seg_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_c2h_seg_framer.sv
// Directed bench for c2h_seg_framer (MAX_BEATS=4, FIFO_DEPTH=16).
module tb_c2h_seg_framer;

  logic        clk;
  logic        rst_n;
  logic        lnk;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
`ifdef C2H_SEG_FRAMER_STATS_EN
  logic [31:0] st_pkt;
  logic [31:0] st_seg;
  logic [31:0] st_drop;
  logic [31:0] drop0;
`endif

  int n_vec;
  int n_bad;
  int sent;
  int got_n;
  logic [63:0] got_data [64];
  logic        got_last [64];

  c2h_seg_framer #(
    .DATA_W     (64),
    .FIFO_DEPTH (16),
    .MAX_BEATS  (4)
  ) dut (
    .clk           (clk),
    .sys_rst_n     (rst_n),
    .user_lnk_up   (lnk),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .busy          (busy)
`ifdef C2H_SEG_FRAMER_STATS_EN
    ,
    .stat_pkt_cnt  (st_pkt),
    .stat_seg_cnt  (st_seg),
    .stat_drop_cnt (st_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    logic        e_sr;
    logic        e_mv;
    logic [63:0] e_md;
    logic [7:0]  e_mk;
    logic        e_ml;
  } vec_t;

  vec_t tab [12];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends an n-beat packet with m_ready=1 and checks what emerges (segment starts at beat 0).
  task automatic send_pkt(input int n, input logic [63:0] base);
    int s;
    s     = 0;
    got_n = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 200 && got_n < n; c++) begin
      s_valid = (s < n);
      s_data  = base + 64'(s);
      s_keep  = 8'hFF;
      s_last  = (s == n - 1);
      #2;
      if (m_valid && m_ready && got_n < 64) begin
        got_data[got_n] = m_data;
        got_last[got_n] = m_last;
        got_n++;
      end
      if (s_valid && s_ready) s++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk64("pkt_len", 64'(got_n), 64'(n));
    for (int j = 0; j < n && j < got_n; j++) begin
      chk64("pkt_data", got_data[j], base + 64'(j));
      chk1("pkt_last", got_last[j], (j == n - 1) || ((j % 4) == 3));
    end
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    lnk     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    tab[0] = '{1'b1, 64'd1, 8'hFF, 1'b0, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0};
    for (int i = 1; i < 10; i++)
      tab[i] = '{1'b1, 64'(i + 1), (i == 9) ? 8'h0F : 8'hFF, (i == 9),
                 1'b1, 1'b1, 64'(i), 8'hFF, ((i % 4) == 0)};
    tab[10] = '{1'b0, 64'd0, 8'h00, 1'b0, 1'b1, 1'b1, 64'd10, 8'h0F, 1'b1};
    tab[11] = '{1'b0, 64'd0, 8'h00, 1'b0, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_m_data", m_data, 64'd0);
    chk64("rst_m_keep", 64'(m_keep), 64'd0);
`ifdef C2H_SEG_FRAMER_STATS_EN
    chk64("rst_stats", 64'(st_pkt | st_seg | st_drop), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Segmentation: 10-beat packet, segments of 4/4/2
    for (int i = 0; i < 12; i++) begin
      s_valid = tab[i].sv;
      s_data  = tab[i].sd;
      s_keep  = tab[i].sk;
      s_last  = tab[i].sl;
      m_ready = 1'b1;
      lnk     = 1'b1;
      #2;
      chk1("seg_s_ready", s_ready, tab[i].e_sr);
      chk1("seg_m_valid", m_valid, tab[i].e_mv);
      if (tab[i].e_mv) begin
        chk64("seg_m_data", m_data, tab[i].e_md);
        chk64("seg_m_keep", 64'(m_keep), 64'(tab[i].e_mk));
        chk1("seg_m_last", m_last, tab[i].e_ml);
      end
      @(posedge clk); #1;
    end
    chk1("seg_busy", busy, 1'b0);
`ifdef C2H_SEG_FRAMER_STATS_EN
    chk64("seg_stat_seg", 64'(st_seg), 64'd3);
    chk64("seg_stat_pkt", 64'(st_pkt), 64'd1);
`endif

    // Backpressure: 20 beats offered with m_ready=0, then full-FIFO push/pop
    m_ready = 1'b0;
    sent    = 0;
    for (int c = 0; c < 16; c++) begin
      s_valid = 1'b1;
      s_data  = 64'(sent + 1);
      s_keep  = 8'hFF;
      s_last  = (sent + 1 == 20);
      #2;
      chk1("bp_ready", s_ready, 1'b1);
      if (s_ready) sent++;
      @(posedge clk); #1;
    end
    s_data  = 64'(sent + 1);
    s_last  = 1'b0;
    m_ready = 1'b1;
    #2;
    chk1("full_ready_t", s_ready, 1'b0);
    chk1("full_valid_t", m_valid, 1'b1);
    chk64("full_head_t", m_data, 64'd1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    #2;
    chk1("full_ready_t1", s_ready, 1'b1);
    chk64("full_head_t1", m_data, 64'd2);
    if (s_ready) sent++;
    @(posedge clk); #1;
    s_data = 64'(sent + 1);
    #2;
    chk1("refull_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    got_n   = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 100 && got_n < 19; c++) begin
      s_valid = (sent < 20);
      s_data  = 64'(sent + 1);
      s_last  = (sent + 1 == 20);
      #2;
      if (m_valid && got_n < 64) begin
        got_data[got_n] = m_data;
        got_last[got_n] = m_last;
        got_n++;
      end
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk64("bp_drain_len", 64'(got_n), 64'd19);
    for (int j = 0; j < got_n && j < 19; j++) begin
      chk64("bp_data", got_data[j], 64'(j + 2));
      chk1("bp_last", got_last[j], (((j + 2) % 4) == 0));
    end
    #2;
    chk1("bp_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Link loss mid-packet
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1;
      s_data  = 64'h100 + 64'(c);
      s_keep  = 8'hFF;
      s_last  = 1'b0;
      #2;
      chk1("ll_accept", s_ready, 1'b1);
      @(posedge clk); #1;
    end
`ifdef C2H_SEG_FRAMER_STATS_EN
    drop0 = st_drop;
`endif
    s_valid = 1'b0;
    lnk     = 1'b0;
    #2;
    chk1("ll_ready_down", s_ready, 1'b0);
    chk1("ll_valid_down", m_valid, 1'b1);
    @(posedge clk); #1;
    lnk = 1'b1;
    #2;
    chk1("ll_valid_after", m_valid, 1'b0);
    chk1("ll_drop_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1;
      s_data  = 64'h103 + 64'(c);
      s_last  = (c == 4);
      m_ready = 1'b1;
      #2;
      chk1("ll_drop_ready", s_ready, 1'b1);
      chk1("ll_drop_valid", m_valid, 1'b0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    #2;
    chk1("ll_busy", busy, 1'b0);
    chk1("ll_no_output", m_valid, 1'b0);
`ifdef C2H_SEG_FRAMER_STATS_EN
    chk64("ll_drop_cnt", 64'(st_drop), 64'(drop0) + 64'd4);
`endif
    @(posedge clk); #1;
    send_pkt(2, 64'h200);

    // Link down while idle: held off, nothing dropped
`ifdef C2H_SEG_FRAMER_STATS_EN
    drop0 = st_drop;
`endif
    lnk = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1;
      s_data  = 64'h300;
      s_last  = 1'b0;
      #2;
      chk1("idle_down_ready", s_ready, 1'b0);
      chk1("idle_down_valid", m_valid, 1'b0);
      @(posedge clk); #1;
    end
    lnk = 1'b1;
    send_pkt(2, 64'h300);
`ifdef C2H_SEG_FRAMER_STATS_EN
    chk64("idle_drop_cnt", 64'(st_drop), 64'(drop0));
`endif

    // Reset mid-stream
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1;
      s_data  = 64'h400 + 64'(c);
      s_keep  = 8'hFF;
      s_last  = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    #2;
    chk1("pre_rst_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mrst_s_ready", s_ready, 1'b0);
    chk1("mrst_m_valid", m_valid, 1'b0);
    chk1("mrst_m_last", m_last, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk64("mrst_m_data", m_data, 64'd0);
    chk64("mrst_m_keep", 64'(m_keep), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    #2;
    chk1("post_rst_busy", busy, 1'b0);
    chk1("post_rst_valid", m_valid, 1'b0);
    chk1("post_rst_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    send_pkt(1, 64'h500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
